mux_41: RTL and testbench

- Registered 4-to-1 multiplexer.
- Selects one of four WIDTH-bit lanes packed in D using the 2-bit Sel, and registers the result on Out.
- Used as a generic lane-select stage in datapaths that need a clean, glitch-free, clocked select output.
- Single clock domain. Reset is asynchronous and active-low.

---
 rtl/mux_41.sv | 88 ++++++++
 tb/tb_mux_41.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_41.sv
// mux_41: registered 4-to-1 lane multiplexer.
// Four WIDTH-bit lanes are packed in D (lane 0 at the LSBs). Sel picks one
// lane, and that lane is captured into Out on a rising edge with en=1.
// out_valid marks the cycle that follows each capture.
// Optional build macro MUX41_PARITY_EN adds out_par, the XOR-reduction of
// the captured lane, registered alongside Out.
module mux_41 #(
   parameter int WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [4*WIDTH-1:0]   D,
   input  logic [1:0]           Sel,
   output logic [WIDTH-1:0]     Out,
   output logic                 out_valid
`ifdef MUX41_PARITY_EN
   ,
   output logic                 out_par
`endif
);

   logic [WIDTH-1:0] lane_sel;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;
   logic             vld_d;
   logic             vld_q;

   // Lane decode: every Sel code is legal, so no default-lane fallback is needed.
   always_comb begin
      lane_sel = D[WIDTH-1:0];
      case (Sel)
         2'd0:    lane_sel = D[0*WIDTH +: WIDTH];
         2'd1:    lane_sel = D[1*WIDTH +: WIDTH];
         2'd2:    lane_sel = D[2*WIDTH +: WIDTH];
         2'd3:    lane_sel = D[3*WIDTH +: WIDTH];
         default: lane_sel = D[0*WIDTH +: WIDTH];
      endcase
   end

   // Next state: capture the selected lane on en, otherwise hold; valid follows en.
   always_comb begin
      out_d = out_q;
      vld_d = en;
      if (en) begin
         out_d = lane_sel;
      end
   end

   // Output and valid flops; reset clears them at once, independent of clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= '0;
         vld_q <= 1'b0;
      end else begin
         out_q <= out_d;
         vld_q <= vld_d;
      end
   end

   assign Out       = out_q;
   assign out_valid = vld_q;

`ifdef MUX41_PARITY_EN
   logic par_d;
   logic par_q;

   // Parity of the lane being captured; holds with Out when en is low.
   always_comb begin
      par_d = par_q;
      if (en) begin
         par_d = ^lane_sel;
      end
   end

   // Parity flop shares the reset and enable behaviour of Out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   assign out_par = par_q;
`endif

endmodule

// File: tb/tb_mux_41.sv
// tb_mux_41: table-driven bench with a scoreboard queue for mux_41.
// Two instances (WIDTH=1 and WIDTH=8) share clock, reset, en and Sel.
// Define MUX41_PARITY_EN for both files to also check out_par.
module tb_mux_41;

   typedef struct {
      logic        en;
      logic [1:0]  sel;
      logic [3:0]  d1;
      logic [31:0] d8;
      logic        e1;
      logic [7:0]  e8;
      logic        ev;
      logic        ep;
   } rec_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  sel;
   logic [3:0]  d1;
   logic [31:0] d8;
   logic        o1;
   logic [7:0]  o8;
   logic        v1;
   logic        v8;
`ifdef MUX41_PARITY_EN
   logic        p1;
   logic        p8;
`endif

   int compared;
   int mismatched;
   rec_t exp_q[$];
   rec_t vec[13];

   mux_41 #(.WIDTH(1)) u_w1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .D         (d1),
      .Sel       (sel),
      .Out       (o1),
      .out_valid (v1)
`ifdef MUX41_PARITY_EN
      ,
      .out_par   (p1)
`endif
   );

   mux_41 #(.WIDTH(8)) u_w8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .D         (d8),
      .Sel       (sel),
      .Out       (o8),
      .out_valid (v8)
`ifdef MUX41_PARITY_EN
      ,
      .out_par   (p8)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the run is a few hundred ns; anything far longer is a hang.
   initial begin
      #20000;
      $display("FAIL watchdog: time %0t exceeded, required finish before 20000", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic rec_t mk(input logic e, input logic [1:0] s, input logic [3:0] a,
                               input logic [31:0] b, input logic x1, input logic [7:0] x8,
                               input logic xv, input logic xp);
      rec_t r;
      r.en = e; r.sel = s; r.d1 = a; r.d8 = b;
      r.e1 = x1; r.e8 = x8; r.ev = xv; r.ep = xp;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_outputs(input string tag);
      rec_t r;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
         return;
      end
      r = exp_q.pop_front();
      check({tag, " out_w1"},   64'(o1), 64'(r.e1));
      check({tag, " out_w8"},   64'(o8), 64'(r.e8));
      check({tag, " valid_w1"}, 64'(v1), 64'(r.ev));
      check({tag, " valid_w8"}, 64'(v8), 64'(r.ev));
`ifdef MUX41_PARITY_EN
      check({tag, " par_w1"},   64'(p1), 64'(r.e1));
      check({tag, " par_w8"},   64'(p8), 64'(r.ep));
`endif
   endtask

   // Drive one cycle of stimulus on the falling edge, push its expectation,
   // then compare just after the following rising edge.
   task automatic step(input rec_t r, input string tag);
      @(negedge clk);
      en  = r.en;
      sel = r.sel;
      d1  = r.d1;
      d8  = r.d8;
      exp_q.push_back(r);
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;

      //            en    sel    d1       d8            e1    e8     ev    ep
      vec[0]  = mk(1'b1, 2'd0, 4'b0001, 32'hDDCCBBAA, 1'b1, 8'hAA, 1'b1, 1'b0);
      vec[1]  = mk(1'b1, 2'd1, 4'b0101, 32'hDDCCBBAA, 1'b0, 8'hBB, 1'b1, 1'b0);
      vec[2]  = mk(1'b1, 2'd2, 4'b1010, 32'hDDCCBBAA, 1'b0, 8'hCC, 1'b1, 1'b0);
      vec[3]  = mk(1'b1, 2'd3, 4'b1111, 32'hDDCCBBAA, 1'b1, 8'hDD, 1'b1, 1'b0);
      vec[4]  = mk(1'b0, 2'd0, 4'b0000, 32'h00000000, 1'b1, 8'hDD, 1'b0, 1'b0);
      vec[5]  = mk(1'b0, 2'd0, 4'b0000, 32'h00000000, 1'b1, 8'hDD, 1'b0, 1'b0);
      vec[6]  = mk(1'b0, 2'd0, 4'b0000, 32'h00000000, 1'b1, 8'hDD, 1'b0, 1'b0);
      vec[7]  = mk(1'b1, 2'd2, 4'b0100, 32'h00070000, 1'b1, 8'h07, 1'b1, 1'b1);
      vec[8]  = mk(1'b1, 2'd2, 4'b0011, 32'h00030000, 1'b0, 8'h03, 1'b1, 1'b0);
      vec[9]  = mk(1'b1, 2'd1, 4'b0010, 32'h12345678, 1'b1, 8'h56, 1'b1, 1'b0);
      vec[10] = mk(1'b0, 2'd3, 4'b0000, 32'hFFFFFFFF, 1'b1, 8'h56, 1'b0, 1'b0);
      vec[11] = mk(1'b1, 2'd3, 4'b1000, 32'h80000000, 1'b1, 8'h80, 1'b1, 1'b1);
      vec[12] = mk(1'b1, 2'd0, 4'b1110, 32'h000000FE, 1'b0, 8'hFE, 1'b1, 1'b1);

      // Reset state before any clock edge
      rst_n = 1'b1;
      en    = 1'b0;
      sel   = 2'd0;
      d1    = 4'b0000;
      d8    = 32'h0;
      #2;
      rst_n = 1'b0;
      #1;
      check("reset out_w1",   64'(o1), 64'd0);
      check("reset out_w8",   64'(o8), 64'd0);
      check("reset valid_w1", 64'(v1), 64'd0);
      check("reset valid_w8", 64'(v8), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         step(vec[i], $sformatf("vec%0d", i));
      end

      // Reset mid-run: capture a 1, then pull rst_n low between edges
      step(mk(1'b1, 2'd3, 4'b1111, 32'hDDCCBBAA, 1'b1, 8'hDD, 1'b1, 1'b0), "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst out_w1",   64'(o1), 64'd0);
      check("async_rst out_w8",   64'(o8), 64'd0);
      check("async_rst valid_w1", 64'(v1), 64'd0);
      check("async_rst valid_w8", 64'(v8), 64'd0);
      // An edge with rst_n still low must not capture even though en=1
      @(posedge clk);
      #1;
      check("rst_edge out_w1",   64'(o1), 64'd0);
      check("rst_edge out_w8",   64'(o8), 64'd0);
      check("rst_edge valid_w1", 64'(v1), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      // First capture after release uses the inputs sampled on that edge
      step(mk(1'b1, 2'd2, 4'b0100, 32'h005A0000, 1'b1, 8'h5A, 1'b1, 1'b0), "post_rst");
      step(mk(1'b0, 2'd0, 4'b0000, 32'h00000000, 1'b1, 8'h5A, 1'b0, 1'b0), "post_hold");

      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d leftover, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
